// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU operation codes, ALUOp/funct7 constants and FSM states
package alu_ctrl_pkg;
  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_XOR    = 5'b00011,
    OP_SUB    = 5'b00110,
    OP_SLL    = 5'b00111,
    OP_SRL    = 5'b01000,
    OP_SRA    = 5'b01001,
    OP_SLT    = 5'b01010,
    OP_SLTU   = 5'b01011,
    OP_LUI    = 5'b01100,
    OP_BEQ    = 5'b10000,
    OP_BNE    = 5'b10001,
    OP_BLT    = 5'b10100,
    OP_BGE    = 5'b10101,
    OP_BLTU   = 5'b10110,
    OP_BGEU   = 5'b10111,
    OP_MUL    = 5'b11000,
    OP_MULH   = 5'b11001,
    OP_MULHSU = 5'b11010,
    OP_MULHU  = 5'b11011,
    OP_DIV    = 5'b11100,
    OP_DIVU   = 5'b11101,
    OP_REM    = 5'b11110,
    OP_REMU   = 5'b11111
  } alu_op_e;
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [1:0] ALUOP_JL    = 2'b11;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BUSY} state_e;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALUOp/funct3/funct7 -> ALU operation, class and legality
// ports: alu_op/is_imm/funct7/funct3 in; operation, multicycle (MUL/DIV), illegal, is_div out
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic       is_imm,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output alu_op_e    operation,
  output logic       multicycle,
  output logic       illegal,
  output logic       is_div
);
  logic std_f7;
  assign std_f7 = funct7 == F7_BASE || funct7 == F7_ALT;
  always_comb begin
    operation = OP_ADD;
    multicycle = 1'b0;
    illegal = 1'b0;
    is_div = 1'b0;
    case (alu_op)
      ALUOP_JL: operation = OP_LUI;
      ALUOP_BR: begin
        // branch codes are 10 followed by funct3; 010/011 have no branch
        if (funct3[2:1] == 2'b01) illegal = 1'b1;
        else operation = alu_op_e'({2'b10, funct3});
      end
      ALUOP_ARITH: begin
        if (!is_imm && funct7 == F7_MULDIV) begin
          if (ENABLE_M) begin
            operation = alu_op_e'({2'b11, funct3});
            multicycle = 1'b1;
            is_div = funct3[2];
          end else illegal = 1'b1;
        end else if ((!is_imm || funct3[1:0] == 2'b01) && !std_f7) illegal = 1'b1;
        else case (funct3)
          3'b000: operation = (!is_imm && funct7 == F7_ALT) ? OP_SUB : OP_ADD;
          3'b001: operation = OP_SLL;
          3'b010: operation = OP_SLT;
          3'b011: operation = OP_SLTU;
          3'b100: operation = OP_XOR;
          3'b101: operation = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
          3'b110: operation = OP_OR;
          3'b111: operation = OP_AND;
        endcase
      end
      default: operation = OP_ADD;
    endcase
  end
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered RV32I/M ALU-operation decoder behind valid/ready with multi-cycle MUL/DIV hold
// ports: clk, rst_n (async active-low), flush (sync, drops held/in-flight op);
//        in_valid/in_ready with alu_op/is_imm/funct7/funct3 from decode;
//        out_valid/out_ready with operation/multicycle/illegal to execute; mc_start pulses after MUL/DIV accept
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W     = 5,
  parameter bit ENABLE_M = 1'b1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic            is_imm,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] operation,
  output logic            multicycle,
  output logic            illegal,
  output logic            mc_start
);
  alu_op_e d_op, op_q;
  logic d_mc, d_ill, d_div, acc;
  logic [3:0] lat, cnt;
  state_e st;
  alu_op_decode #(.ENABLE_M(ENABLE_M)) u_dec (
    .alu_op(alu_op),
    .is_imm(is_imm),
    .funct7(funct7),
    .funct3(funct3),
    .operation(d_op),
    .multicycle(d_mc),
    .illegal(d_ill),
    .is_div(d_div)
  );
  assign lat = d_div ? 4'(DIV_LAT) : 4'(MUL_LAT);
  assign in_ready = !flush && (st == S_IDLE || (st == S_HOLD && out_ready));
  assign acc = in_valid && in_ready;
  assign operation = OP_W'(op_q);
  // cnt is loaded with LAT-2 so BUSY lasts LAT-1 cycles and out_valid rises LAT cycles after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_IDLE;
      cnt <= 4'd0;
      op_q <= OP_ADD;
      out_valid <= 1'b0;
      multicycle <= 1'b0;
      illegal <= 1'b0;
      mc_start <= 1'b0;
    end else begin
      mc_start <= 1'b0;
      if (flush) begin
        st <= S_IDLE;
        cnt <= 4'd0;
        out_valid <= 1'b0;
      end else if (acc) begin
        op_q <= d_op;
        multicycle <= d_mc;
        illegal <= d_ill;
        if (d_mc && lat > 4'd1) begin
          st <= S_BUSY;
          cnt <= lat - 4'd2;
          out_valid <= 1'b0;
          mc_start <= 1'b1;
        end else begin
          st <= S_HOLD;
          out_valid <= 1'b1;
        end
      end else if (st == S_BUSY) begin
        if (cnt == 4'd0) begin
          st <= S_HOLD;
          out_valid <= 1'b1;
        end else cnt <= cnt - 4'd1;
      end else if (st == S_HOLD && out_ready) begin
        st <= S_IDLE;
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: scoreboard bench for alu_ctrl_seq with a table-driven reference decoder
module tb_alu_ctrl_seq;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam logic [39:0] ARITH = {5'b00000, 5'b00001, 5'b01000, 5'b00011, 5'b01011, 5'b01010, 5'b00111, 5'b00010};
  localparam logic [39:0] BR    = {5'b10111, 5'b10110, 5'b10101, 5'b10100, 5'b00000, 5'b00000, 5'b10001, 5'b10000};
  localparam logic [39:0] MT    = {5'b11111, 5'b11110, 5'b11101, 5'b11100, 5'b11011, 5'b11010, 5'b11001, 5'b11000};
  typedef struct {
    logic [4:0] op;
    logic mc;
    logic ill;
    int acc;
    int lat;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, is_imm = 1'b0, out_ready = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [6:0] funct7 = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic in_ready, out_valid, multicycle, illegal, mc_start;
  logic [4:0] operation;
  logic v2 = 1'b0;
  logic in_ready2, out_valid2, multicycle2, illegal2, mc_start2;
  logic [4:0] operation2;
  exp_t q[$];
  exp_t head;
  int checks = 0, errors = 0, cyc = 0, busy_end = 0, mc_cyc = -100;
  bit mon_en = 1'b0, seen = 1'b0;
  alu_ctrl_seq #(.OP_W(5), .ENABLE_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .is_imm(is_imm), .funct7(funct7), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
    .multicycle(multicycle), .illegal(illegal), .mc_start(mc_start)
  );
  alu_ctrl_seq #(.OP_W(5), .ENABLE_M(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v2), .in_ready(in_ready2),
    .alu_op(alu_op), .is_imm(is_imm), .funct7(funct7), .funct3(funct3),
    .out_valid(out_valid2), .out_ready(1'b1), .operation(operation2),
    .multicycle(multicycle2), .illegal(illegal2), .mc_start(mc_start2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  function automatic logic [6:0] model(input logic [1:0] ao, input logic im, input logic [6:0] f7,
                                       input logic [2:0] f3, input bit em);
    logic [4:0] op;
    logic mc, ill;
    int k;
    bit r, std;
    k = int'(f3) * 5;
    op = 5'b00010;
    mc = 1'b0;
    ill = 1'b0;
    r = !im;
    std = f7 == 7'h00 || f7 == 7'h20;
    if (ao == 2'b11) op = 5'b01100;
    else if (ao == 2'b01) begin
      if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
      else op = BR[k +: 5];
    end else if (ao == 2'b10) begin
      if (r && f7 == 7'h01) begin
        if (em) begin
          op = MT[k +: 5];
          mc = 1'b1;
        end else ill = 1'b1;
      end else if ((r || f3 == 3'd1 || f3 == 3'd5) && !std) ill = 1'b1;
      else begin
        op = ARITH[k +: 5];
        if (f3 == 3'd0 && r && f7 == 7'h20) op = 5'b00110;
        if (f3 == 3'd5 && f7 == 7'h20) op = 5'b01001;
      end
    end
    return {op, mc, ill};
  endfunction
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mc_start", 32'(mc_start), 32'(cyc == mc_cyc));
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
        else begin
          head = q[0];
          if (!seen) begin
            chk("latency", cyc, head.acc + head.lat - 1);
            seen = 1'b1;
          end
          chk("operation", 32'(operation), 32'(head.op));
          chk("multicycle", 32'(multicycle), 32'(head.mc));
          chk("illegal", 32'(illegal), 32'(head.ill));
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end
  task automatic drive(input bit v, input logic [1:0] ao, input logic im, input logic [6:0] f7,
                       input logic [2:0] f3, input bit ordy, output bit acc);
    logic [6:0] e;
    int l;
    @(posedge clk);
    #1;
    in_valid = v;
    alu_op = ao;
    is_imm = im;
    funct7 = f7;
    funct3 = f3;
    out_ready = ordy;
    @(negedge clk);
    #1;
    chk("in_ready", 32'(in_ready), 32'(!(cyc < busy_end || q.size() > 0)));
    acc = v && in_ready;
    if (acc) begin
      e = model(ao, im, f7, f3, 1'b1);
      l = !e[1] ? 1 : (f3[2] ? DIV_LAT : MUL_LAT);
      q.push_back('{op: e[6:2], mc: e[1], ill: e[0], acc: cyc + 1, lat: l});
      busy_end = cyc + l;
      if (l > 1) mc_cyc = cyc + 1;
    end
  endtask
  task automatic issue(input logic [1:0] ao, input logic im, input logic [6:0] f7, input logic [2:0] f3,
                       input bit ordy);
    bit a = 1'b0;
    for (int i = 0; i < 40 && !a; i++) drive(1'b1, ao, im, f7, f3, ordy, a);
    chk("accepted", 32'(a), 32'd1);
  endtask
  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, 7'd0, 3'd0, ordy, a);
  endtask
  task automatic drain();
    bit a;
    for (int i = 0; i < 40 && q.size() > 0; i++) drive(1'b0, 2'b00, 1'b0, 7'd0, 3'd0, 1'b1, a);
    chk("drained", q.size(), 0);
  endtask
  task automatic start_div();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    alu_op = 2'b10;
    is_imm = 1'b0;
    funct7 = 7'h01;
    funct3 = 3'b100;
    out_ready = 1'b1;
    @(negedge clk);
    chk("div_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  initial begin
    logic [6:0] e;
    logic [6:0] f7;
    bit a;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_operation", 32'(operation), 32'h02);
    chk("rst_multicycle", 32'(multicycle), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_mc_start", 32'(mc_start), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    issue(2'b10, 1'b0, 7'h00, 3'b000, 1'b1);
    issue(2'b10, 1'b0, 7'h20, 3'b000, 1'b1);
    issue(2'b10, 1'b1, 7'h20, 3'b000, 1'b1);
    issue(2'b01, 1'b0, 7'h00, 3'b000, 1'b1);
    issue(2'b01, 1'b0, 7'h00, 3'b001, 1'b1);
    issue(2'b01, 1'b0, 7'h00, 3'b100, 1'b1);
    issue(2'b01, 1'b0, 7'h00, 3'b101, 1'b1);
    issue(2'b10, 1'b0, 7'h01, 3'b000, 1'b1);
    drain();
    issue(2'b10, 1'b0, 7'h00, 3'b111, 1'b0);
    idle(4, 1'b0);
    issue(2'b10, 1'b0, 7'h20, 3'b101, 1'b1);
    issue(2'b10, 1'b0, 7'h7f, 3'b000, 1'b1);
    issue(2'b00, 1'b0, 7'h00, 3'b000, 1'b1);
    issue(2'b11, 1'b0, 7'h00, 3'b000, 1'b1);
    issue(2'b01, 1'b0, 7'h00, 3'b010, 1'b1);
    issue(2'b10, 1'b0, 7'h01, 3'b110, 1'b1);
    drain();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      drive($urandom_range(9) < 7, 2'($urandom), 1'($urandom), f7, 3'($urandom), $urandom_range(3) != 0, a);
    end
    drain();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    v2 = 1'b1;
    alu_op = 2'b10;
    is_imm = 1'b0;
    funct7 = 7'h01;
    funct3 = 3'b000;
    @(negedge clk);
    chk("nm_in_ready", 32'(in_ready2), 32'd1);
    @(posedge clk);
    #1;
    v2 = 1'b0;
    e = model(2'b10, 1'b0, 7'h01, 3'b000, 1'b0);
    @(negedge clk);
    chk("nm_out_valid", 32'(out_valid2), 32'd1);
    chk("nm_illegal", 32'(illegal2), 32'(e[0]));
    chk("nm_operation", 32'(operation2), 32'(e[6:2]));
    chk("nm_multicycle", 32'(multicycle2), 32'(e[1]));
    chk("nm_mc_start", 32'(mc_start2), 32'd0);
    mon_en = 1'b0;
    start_div();
    @(negedge clk);
    chk("div_mc_start", 32'(mc_start), 32'd1);
    chk("div_busy_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    funct7 = 7'h00;
    funct3 = 3'b000;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_mc_start", 32'(mc_start), 32'd0);
      @(negedge clk);
    end
    start_div();
    #1;
    chk("pre_rst_mc_start", 32'(mc_start), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_mc_start", 32'(mc_start), 32'd0);
    chk("arst_operation", 32'(operation), 32'h02);
    chk("arst_multicycle", 32'(multicycle), 32'd0);
    chk("arst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_mc_start", 32'(mc_start), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
